mul_seq: RTL and testbench

Multi-cycle shift-add multiplier sequencer for the LEGv8 `MUL` instruction. It computes the low 64 bits of A×B by driving the shared 64-bit ALU in `ALU_ADD` mode, one partial product per cycle. The ALU sits outside this block; `mul_seq` only drives its `A`, `B` and `cntrl` inputs and consumes `result`. It sits beside the EX stage, and the pipeline stalls while `busy` is high.

---
 rtl/alu_pkg.sv | 10 +
 rtl/mul_seq.sv | 76 +++++++
 tb/tb_mul_seq.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: ALU control encodings and the multiply sequencer state type.
package alu_pkg;
    localparam logic [2:0] ALU_PASS_B   = 3'b000;
    localparam logic [2:0] ALU_ADD      = 3'b010;
    localparam logic [2:0] ALU_SUBTRACT = 3'b011;
    localparam logic [2:0] ALU_AND      = 3'b100;
    localparam logic [2:0] ALU_OR       = 3'b101;
    localparam logic [2:0] ALU_XOR      = 3'b110;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
endpackage

// File: rtl/mul_seq.sv
// mul_seq: shift-add multiplier driving the shared ALU, one partial product per cycle.
module mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [2:0]       alu_cntrl,
    input  logic [WIDTH-1:0] alu_result
);
    mul_state_t state;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic run;
    assign run       = state == RUN;
    assign alu_cntrl = run ? ALU_ADD : ALU_PASS_B;
    assign alu_A     = run ? acc : '0;
    assign alu_B     = (run && mplier[0]) ? mcand : '0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc    <= '0;
                    mcand  <= a;
                    mplier <= b;
                    state  <= RUN;
                    ready  <= 1'b0;
                    busy   <= 1'b1;
                end
                RUN: begin
                    if (mplier != '0) begin
                        acc    <= alu_result;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                    // last step: the remaining multiplier has at most bit 0 set
                    if (mplier[WIDTH-1:1] == '0) begin
                        product <= (mplier == '0) ? acc : alu_result;
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed and random multiplies against a scoreboard, with an ALU model attached.
module tb_mul_seq;
    import alu_pkg::*;
    localparam int W = 64;

    logic clk = 1'b0;
    logic reset, start;
    logic [W-1:0] a, b, product, alu_A, alu_B, alu_result;
    logic ready, busy, done;
    logic [2:0] alu_cntrl;

    typedef struct {
        logic [W-1:0] prod;
        int           n;
    } exp_t;
    exp_t sb[$];
    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mul_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .ready(ready), .busy(busy), .done(done), .product(product),
        .alu_A(alu_A), .alu_B(alu_B), .alu_cntrl(alu_cntrl), .alu_result(alu_result)
    );

    always_comb begin
        alu_result = '0;
        case (alu_cntrl)
            ALU_PASS_B:   alu_result = alu_B;
            ALU_ADD:      alu_result = alu_A + alu_B;
            ALU_SUBTRACT: alu_result = alu_A - alu_B;
            ALU_AND:      alu_result = alu_A & alu_B;
            ALU_OR:       alu_result = alu_A | alu_B;
            ALU_XOR:      alu_result = alu_A ^ alu_B;
            default:      alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int n_of(input logic [W-1:0] v);
        int n = 1;
        for (int i = 0; i < W; i++) if (v[i]) n = i + 1;
        return n;
    endfunction

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        @(negedge clk);
        chk("ready_before_start", ready, 1);
        a = x;
        b = y;
        start = 1'b1;
        e.prod = x * y;
        e.n = n_of(y);
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        chk("busy_after_accept", busy, 1);
        chk("alu_cntrl_run", alu_cntrl, ALU_ADD);
    endtask

    task automatic wait_done(input int already, input string tag);
        int run = already;
        bit seen = 0;
        exp_t e;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
            else if (busy) run++;
        end
        chk({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            chk({tag, "_ready_low_in_done"}, {ready, busy}, 0);
            chk({tag, "_sb_nonempty"}, sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({tag, "_product"}, product, e.prod);
                chk({tag, "_run_cycles"}, run, e.n);
            end
            @(negedge clk);
            chk({tag, "_done_one_cycle"}, done, 0);
            chk({tag, "_ready_back"}, ready, 1);
        end
    endtask

    initial begin
        int extra;
        logic [W-1:0] x, y;
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        chk("rst_flags", {ready, busy, done}, 3'b100);
        chk("rst_product", product, 0);
        chk("rst_alu_cntrl", alu_cntrl, ALU_PASS_B);
        chk("rst_alu_ab", {alu_A, alu_B}, 0);
        reset = 1'b0;

        issue(64'd3, 64'd5);
        wait_done(0, "m3x5");
        issue(64'h1234, 64'd0);
        wait_done(0, "b_zero");
        issue('1, '1);
        wait_done(0, "all_ones");
        issue(64'h8000_0000_0000_0001, 64'd2);
        wait_done(0, "msb_out");

        issue(64'd7, 64'd9);
        start = 1'b1;
        a = 64'd1;
        b = 64'd1;
        @(negedge clk);
        chk("ign_busy", busy, 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1, "ignored_start");
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("no_second_done", extra, 0);

        for (int i = 0; i < 4; i++) begin
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            y = y >> $urandom_range(0, 60);
            issue(x, y);
            wait_done(0, "random");
        end

        issue('1, '1);
        repeat (10) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_flags", {ready, busy, done}, 3'b100);
        chk("mid_rst_product", product, 0);
        chk("mid_rst_alu_cntrl", alu_cntrl, ALU_PASS_B);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        extra = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("no_done_after_rst", extra, 0);
        chk("product_after_rst", product, 0);
        issue(64'd6, 64'd7);
        wait_done(0, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
